// File: rtl/stopwatch_controller.sv
`default_nettype none
// ============================================================================
// stopwatch_controller: run-control FSM that gates the 1 s tick into the BCD
// counters, issues the counter clear and freezes a lap snapshot for display.
// Revision: 1.0
// ============================================================================
module stopwatch_controller #(
  parameter int                    DIGITS_WIDTH = 12,
  parameter logic [DIGITS_WIDTH-1:0] MAX_VALUE  = 12'h959,
  parameter bit                    STOP_AT_MAX  = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    tick,
  input  logic                    btn_start_stop,
  input  logic                    btn_lap_reset,
  input  logic [DIGITS_WIDTH-1:0] digits_in,
  output logic                    count_enable,
  output logic                    counter_clear,
  output logic [DIGITS_WIDTH-1:0] digits_out,
  output logic [1:0]              state
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_RUNNING = 2'b01,
    ST_STOPPED = 2'b10,
    ST_LAP     = 2'b11
  } state_t;

  state_t                  r_state;
  logic                    r_ss_sync1, r_ss_sync2, r_ss_prev;
  logic                    r_lr_sync1, r_lr_sync2, r_lr_prev;
  logic                    r_clear;
  logic [DIGITS_WIDTH-1:0] r_snapshot;

  logic w_ss_edge;
  logic w_lr_edge;
  logic w_counting;
  logic w_at_max;
  logic w_max_stop;

  assign w_ss_edge  = r_ss_sync2 & ~r_ss_prev;
  assign w_lr_edge  = r_lr_sync2 & ~r_lr_prev;
  assign w_counting = (r_state == ST_RUNNING) || (r_state == ST_LAP);
  // At full scale the tick that would roll the counters over is swallowed
  // and instead drives the FSM into STOPPED.
  assign w_at_max   = STOP_AT_MAX && w_counting && (digits_in == MAX_VALUE);
  assign w_max_stop = tick & w_at_max;

  assign count_enable  = tick & w_counting & ~w_at_max;
  assign counter_clear = r_clear;
  assign digits_out    = (r_state == ST_LAP) ? r_snapshot : digits_in;
  assign state         = r_state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_ss_sync1 <= 1'b0;
      r_ss_sync2 <= 1'b0;
      r_ss_prev  <= 1'b0;
      r_lr_sync1 <= 1'b0;
      r_lr_sync2 <= 1'b0;
      r_lr_prev  <= 1'b0;
      r_clear    <= 1'b0;
      r_snapshot <= '0;
    end else begin
      r_ss_sync1 <= btn_start_stop;
      r_ss_sync2 <= r_ss_sync1;
      r_ss_prev  <= r_ss_sync2;
      r_lr_sync1 <= btn_lap_reset;
      r_lr_sync2 <= r_lr_sync1;
      r_lr_prev  <= r_lr_sync2;
      r_clear    <= 1'b0;

      // Start/stop outranks lap/reset when both edges land together.
      case (r_state)
        ST_IDLE: begin
          if (w_ss_edge) r_state <= ST_RUNNING;
        end
        ST_RUNNING: begin
          if (w_ss_edge) begin
            r_state <= ST_STOPPED;
          end else if (w_max_stop) begin
            r_state <= ST_STOPPED;
          end else if (w_lr_edge) begin
            r_state    <= ST_LAP;
            r_snapshot <= digits_in;
          end
        end
        ST_LAP: begin
          if (w_ss_edge || w_max_stop) begin
            r_state <= ST_STOPPED;
          end else if (w_lr_edge) begin
            r_state <= ST_RUNNING;
          end
        end
        ST_STOPPED: begin
          if (w_ss_edge) begin
            r_state <= ST_RUNNING;
          end else if (w_lr_edge) begin
            r_state <= ST_IDLE;
            r_clear <= 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire
